decode_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational step decoder. Captures one fetched instruction word, decodes opcode plus ModRM byte, and issues its register-transfer micro-steps one per accepted cycle.
- Each micro-step is a (reg_load, select) pair for the ALU/register-file datapath. On retirement the block reports the instruction byte length for the eip adder.
- Sits between fetch and the ALU/register-file control. Adds backpressure, illegal-opcode trapping and a configurable step limit.

---
 rtl/decode_seq.sv | 186 ++++++++++++++++++
 tb/tb_decode_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_seq.sv
// Handshaked instruction step sequencer: captures one fetched word, decodes opcode plus ModRM
// and issues its (reg_load, select) micro-steps, then reports the byte length for the eip adder.
module decode_seq #(
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned MAX_UOPS    = 3,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned LEN_W       = 4,
  localparam int unsigned IdxW       = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1
) (
  input  logic                     clk2,
  input  logic                     reset,
  input  logic [8*FETCH_BYTES-1:0] ope,
  input  logic                     ope_valid,
  output logic                     ope_ready,
  output logic                     uop_valid,
  input  logic                     uop_ready,
  output logic [SEL_W-1:0]         reg_load,
  output logic [SEL_W-1:0]         select,
  output logic [IdxW-1:0]          uop_idx,
  output logic                     uop_last,
  output logic [LEN_W-1:0]         len,
  output logic                     len_valid,
  output logic                     illegal
);

  typedef enum logic [1:0] {StIdle, StIssue, StHalt} state_e;

  // Table holds at most three steps; codes and lengths fit in three bits.
  typedef struct packed {
    logic [1:0]      cnt;
    logic [2:0]      len;
    logic [2:0][2:0] ld;
    logic [2:0][2:0] sel;
  } entry_t;

  function automatic entry_t mk(input logic [1:0] cnt, input logic [2:0] len,
                                input logic [2:0] l0, input logic [2:0] s0,
                                input logic [2:0] l1, input logic [2:0] s1,
                                input logic [2:0] l2, input logic [2:0] s2);
    entry_t e;
    e.cnt = cnt;
    e.len = len;
    e.ld  = {l2, l1, l0};
    e.sel = {s2, s1, s0};
    return e;
  endfunction

  // cnt == 0 marks an undefined opcode/ModRM combination.
  function automatic entry_t decode(input logic [7:0] op, input logic [7:0] modrm);
    entry_t e;
    e = '0;
    case (op)
      8'h55: e = mk(2'd2, 3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0);
      8'h53: e = mk(2'd2, 3'd1, 3'd1, 3'd2, 3'd1, 3'd7, 3'd0, 3'd0);
      8'h89: begin
        if (modrm == 8'he5)      e = mk(2'd1, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
        else if (modrm == 8'hc3) e = mk(2'd1, 3'd2, 3'd2, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0);
      end
      8'hb8: e = mk(2'd1, 3'd5, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0);
      8'h5d: e = mk(2'd2, 3'd1, 3'd2, 3'd4, 3'd2, 3'd2, 3'd0, 3'd0);
      8'hc3: e = mk(2'd2, 3'd1, 3'd4, 3'd4, 3'd2, 3'd2, 3'd0, 3'd0);
      8'he8: e = mk(2'd3, 3'd5, 3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd2);
      8'h6a: e = mk(2'd2, 3'd2, 3'd1, 3'd2, 3'd1, 3'd4, 3'd0, 3'd0);
      8'h8b: begin
        if (modrm[7:3] == 5'b01000)      e = mk(2'd2, 3'd3, 3'd5, 3'd5, 3'd3, 3'd6, 3'd0, 3'd0);
        else if (modrm[7:3] == 5'b10000) e = mk(2'd2, 3'd6, 3'd5, 3'd5, 3'd3, 3'd6, 3'd0, 3'd0);
      end
      8'h83: begin
        if (modrm == 8'he8)              e = mk(2'd1, 3'd3, 3'd3, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0);
        else if (modrm == 8'hc4)         e = mk(2'd1, 3'd3, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
        else if (modrm == 8'hec)         e = mk(2'd1, 3'd3, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
        else if (modrm[7:3] == 5'b01111) e = mk(2'd2, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd0, 3'd0);
      end
      8'hc9: e = mk(2'd3, 3'd1, 3'd1, 3'd5, 3'd5, 3'd5, 3'd2, 3'd1);
      default: e = '0;
    endcase
    return e;
  endfunction

  logic [7:0] op_byte;
  logic [7:0] modrm_byte;
  assign op_byte    = ope[8*FETCH_BYTES-1 -: 8];
  assign modrm_byte = ope[8*FETCH_BYTES-9 -: 8];

  if (FETCH_BYTES > 2) begin : g_unused
    logic unused_ope;
    assign unused_ope = ^ope[8*FETCH_BYTES-17:0];
  end

  entry_t dec;
  logic   dec_illegal;
  assign dec         = decode(op_byte, modrm_byte);
  // Entries longer than the configured step limit are trapped like undefined opcodes.
  assign dec_illegal = (dec.cnt == 2'd0) || (int'(dec.cnt) > int'(MAX_UOPS));

  state_e          state_q, state_d;
  entry_t          ent_q, ent_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            len_valid_q, len_valid_d;

  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ent_q       <= '0;
      idx_q       <= '0;
      len_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ent_q       <= ent_d;
      idx_q       <= idx_d;
      len_valid_q <= len_valid_d;
    end
  end

  logic       step_last;
  logic [2:0] step_ld;
  logic [2:0] step_sel;

  always_comb begin
    step_ld  = 3'd0;
    step_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      if (int'(idx_q) == i) begin
        step_ld  = ent_q.ld[i];
        step_sel = ent_q.sel[i];
      end
    end
    step_last = (int'(idx_q) == int'(ent_q.cnt) - 1);
  end

  always_comb begin
    state_d     = state_q;
    ent_d       = ent_q;
    idx_d       = idx_q;
    len_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (ope_valid) begin
          ent_d   = dec;
          idx_d   = '0;
          state_d = dec_illegal ? StHalt : StIssue;
        end
      end
      StIssue: begin
        if (uop_ready) begin
          if (step_last) begin
            idx_d       = '0;
            state_d     = StIdle;
            len_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ope_ready = 1'b0;
    uop_valid = 1'b0;
    reg_load  = '0;
    select    = '0;
    uop_idx   = '0;
    uop_last  = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      StIdle:  ope_ready = 1'b1;
      StIssue: begin
        uop_valid = 1'b1;
        reg_load  = SEL_W'(step_ld);
        select    = SEL_W'(step_sel);
        uop_idx   = idx_q;
        uop_last  = step_last;
      end
      StHalt:  illegal = 1'b1;
      default: ope_ready = 1'b0;
    endcase
  end

  // ent_q may be overwritten by a capture in the len_valid cycle; that lands on the next edge.
  assign len_valid = len_valid_q;
  assign len       = len_valid_q ? LEN_W'(ent_q.len) : '0;

endmodule

// File: tb/tb_decode_seq.sv
// Directed bench for decode_seq: a default instance (MAX_UOPS=3) and a MAX_UOPS=2 instance.
module tb_decode_seq;

  logic        clk2 = 1'b0;
  logic        reset;

  logic [31:0] a_ope;
  logic        a_ope_valid, a_ope_ready, a_uop_valid, a_uop_ready;
  logic [3:0]  a_reg_load, a_select, a_len;
  logic [1:0]  a_uop_idx;
  logic        a_uop_last, a_len_valid, a_illegal;

  logic [31:0] b_ope;
  logic        b_ope_valid, b_ope_ready, b_uop_valid, b_uop_ready;
  logic [3:0]  b_reg_load, b_select, b_len;
  logic [0:0]  b_uop_idx;
  logic        b_uop_last, b_len_valid, b_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk2 = ~clk2;

  decode_seq u_dut_a (
    .clk2      (clk2),
    .reset     (reset),
    .ope       (a_ope),
    .ope_valid (a_ope_valid),
    .ope_ready (a_ope_ready),
    .uop_valid (a_uop_valid),
    .uop_ready (a_uop_ready),
    .reg_load  (a_reg_load),
    .select    (a_select),
    .uop_idx   (a_uop_idx),
    .uop_last  (a_uop_last),
    .len       (a_len),
    .len_valid (a_len_valid),
    .illegal   (a_illegal)
  );

  decode_seq #(.MAX_UOPS(2)) u_dut_b (
    .clk2      (clk2),
    .reset     (reset),
    .ope       (b_ope),
    .ope_valid (b_ope_valid),
    .ope_ready (b_ope_ready),
    .uop_valid (b_uop_valid),
    .uop_ready (b_uop_ready),
    .reg_load  (b_reg_load),
    .select    (b_select),
    .uop_idx   (b_uop_idx),
    .uop_last  (b_uop_last),
    .len       (b_len),
    .len_valid (b_len_valid),
    .illegal   (b_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk2);
    #1;
  endtask

  // Checks the visible step of instance A: valid, load, select, index, last.
  task automatic step_a(input string tag, input logic [3:0] ld, input logic [3:0] sel,
                        input logic [1:0] idx, input logic last);
    chk({tag, ".valid"}, 32'(a_uop_valid), 32'd1);
    chk({tag, ".load"},  32'(a_reg_load),  32'(ld));
    chk({tag, ".sel"},   32'(a_select),    32'(sel));
    chk({tag, ".idx"},   32'(a_uop_idx),   32'(idx));
    chk({tag, ".last"},  32'(a_uop_last),  32'(last));
    chk({tag, ".lenv"},  32'(a_len_valid), 32'd0);
  endtask

  task automatic retire_a(input string tag, input logic [3:0] l);
    chk({tag, ".lenv"},  32'(a_len_valid), 32'd1);
    chk({tag, ".len"},   32'(a_len),       32'(l));
    chk({tag, ".uopv"},  32'(a_uop_valid), 32'd0);
    chk({tag, ".ready"}, 32'(a_ope_ready), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    a_ope       = '0;
    a_ope_valid = 1'b0;
    a_uop_ready = 1'b0;
    b_ope       = '0;
    b_ope_valid = 1'b0;
    b_uop_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    chk("rst.ready", 32'(a_ope_ready), 32'd1);
    chk("rst.uopv",  32'(a_uop_valid), 32'd0);
    chk("rst.lenv",  32'(a_len_valid), 32'd0);
    chk("rst.len",   32'(a_len),       32'd0);
    chk("rst.ill",   32'(a_illegal),   32'd0);
    chk("rst.load",  32'(a_reg_load),  32'd0);
    chk("rst.sel",   32'(a_select),    32'd0);
    chk("rst.idx",   32'(a_uop_idx),   32'd0);

    // push ebp
    a_ope = 32'h55AA_BBCC; a_ope_valid = 1'b1; a_uop_ready = 1'b1;
    cyc();
    a_ope_valid = 1'b0;
    step_a("p55.s0", 4'd1, 4'd2, 2'd0, 1'b0);
    chk("p55.s0.ready", 32'(a_ope_ready), 32'd0);
    cyc();
    step_a("p55.s1", 4'd1, 4'd1, 2'd1, 1'b1);
    cyc();
    retire_a("p55.ret", 4'd1);
    cyc();
    chk("p55.post.lenv", 32'(a_len_valid), 32'd0);
    chk("p55.post.len",  32'(a_len),       32'd0);

    // call with a two-cycle stall on step 1
    a_ope = 32'hE800_0000; a_ope_valid = 1'b1;
    cyc();
    a_ope_valid = 1'b0;
    step_a("e8.s0", 4'd1, 4'd2, 2'd0, 1'b0);
    cyc();
    step_a("e8.s1", 4'd1, 4'd3, 2'd1, 1'b0);
    a_uop_ready = 1'b0;
    cyc();
    step_a("e8.stall1", 4'd1, 4'd3, 2'd1, 1'b0);
    cyc();
    step_a("e8.stall2", 4'd1, 4'd3, 2'd1, 1'b0);
    a_uop_ready = 1'b1;
    cyc();
    step_a("e8.s2", 4'd4, 4'd2, 2'd2, 1'b1);
    cyc();
    retire_a("e8.ret", 4'd5);

    // 8B/45 then 83/7D, second captured in the len_valid cycle
    a_ope = 32'h8B45_0000; a_ope_valid = 1'b1;
    cyc();
    a_ope = 32'h837D_0000;
    step_a("8b.s0", 4'd5, 4'd5, 2'd0, 1'b0);
    cyc();
    step_a("8b.s1", 4'd3, 4'd6, 2'd1, 1'b1);
    cyc();
    retire_a("8b.ret", 4'd3);
    cyc();
    a_ope_valid = 1'b0;
    step_a("83.s0", 4'd5, 4'd5, 2'd0, 1'b0);
    cyc();
    step_a("83.s1", 4'd6, 4'd6, 2'd1, 1'b1);
    cyc();
    retire_a("83.ret", 4'd4);

    // Back-to-back one-step instructions retire every two cycles
    a_ope = 32'hB800_0000; a_ope_valid = 1'b1;
    cyc();
    a_ope = 32'h89E5_0000;
    step_a("b8.s0", 4'd3, 4'd3, 2'd0, 1'b1);
    cyc();
    retire_a("b8.ret", 4'd5);
    cyc();
    a_ope_valid = 1'b0;
    step_a("89e5.s0", 4'd2, 4'd2, 2'd0, 1'b1);
    cyc();
    retire_a("89e5.ret", 4'd1 + 4'd1);

    // leave: three steps legal on A, over the limit on B
    a_ope = 32'hC900_0000; a_ope_valid = 1'b1;
    b_ope = 32'hC900_0000; b_ope_valid = 1'b1; b_uop_ready = 1'b1;
    cyc();
    a_ope_valid = 1'b0;
    b_ope_valid = 1'b0;
    step_a("c9.s0", 4'd1, 4'd5, 2'd0, 1'b0);
    chk("c9b.ill",   32'(b_illegal),   32'd1);
    chk("c9b.uopv",  32'(b_uop_valid), 32'd0);
    chk("c9b.ready", 32'(b_ope_ready), 32'd0);
    cyc();
    step_a("c9.s1", 4'd5, 4'd5, 2'd1, 1'b0);
    chk("c9b.uopv1", 32'(b_uop_valid), 32'd0);
    cyc();
    step_a("c9.s2", 4'd2, 4'd1, 2'd2, 1'b1);
    cyc();
    retire_a("c9.ret", 4'd1);
    chk("c9b.lenv", 32'(b_len_valid), 32'd0);
    chk("c9b.ill2", 32'(b_illegal),   32'd1);

    // Undefined ModRM traps and sticks
    a_ope = 32'h89C0_0000; a_ope_valid = 1'b1;
    cyc();
    a_ope_valid = 1'b0;
    chk("halt.ill",   32'(a_illegal),   32'd1);
    chk("halt.ready", 32'(a_ope_ready), 32'd0);
    chk("halt.uopv",  32'(a_uop_valid), 32'd0);
    a_ope = 32'h5500_0000; a_ope_valid = 1'b1;
    cyc();
    cyc();
    chk("halt.stick.ill",   32'(a_illegal),   32'd1);
    chk("halt.stick.ready", 32'(a_ope_ready), 32'd0);
    chk("halt.stick.uopv",  32'(a_uop_valid), 32'd0);
    a_ope_valid = 1'b0;

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    chk("arst.ill",   32'(a_illegal),   32'd0);
    chk("arst.ready", 32'(a_ope_ready), 32'd1);
    chk("arst.uopv",  32'(a_uop_valid), 32'd0);
    chk("arst.b.ill", 32'(b_illegal),   32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // Reset mid-issue abandons the instruction without len_valid
    a_ope = 32'h6A05_0000; a_ope_valid = 1'b1;
    cyc();
    a_ope_valid = 1'b0;
    step_a("6a.s0", 4'd1, 4'd2, 2'd0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("6a.arst.uopv", 32'(a_uop_valid), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("6a.arst.lenv", 32'(a_len_valid), 32'd0);
    chk("6a.arst.ready", 32'(a_ope_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
